// File: rtl/pc_fetch_ctrl.sv
// PC register and non-pipelined instruction-fetch sequencer (IDLE/REQ/WAIT/HOLD).
// Optional macro PC_MISALIGN_TRAP_EN redirects misaligned PC loads to TRAP_PC.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        misalign_trap,
  output logic [31:0] misalign_epc,
`endif
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [1:0]  state_reg, state_next;
  logic        drop_reg, drop_next;
  logic [31:0] pc_reg;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_pc_reg, if_instr_reg;
  logic        pc_load, capture, misaligned;
  logic [31:0] pc_load_val;

  // Redirect wins over everything, except in IDLE where it is ignored.
  assign pc_load    = (state_reg != IDLE) &&
                      (redirect || (state_reg == HOLD && if_valid_reg && if_ready));
  assign misaligned = TRAP_EN && (next_pc[1:0] != 2'b00);
  assign pc_load_val = misaligned ? TRAP_PC : {next_pc[31:2], 2'b00};
  assign capture    = (state_reg == WAIT) && imem_rsp_valid && !drop_reg && !redirect;

  always_comb begin
    state_next    = state_reg;
    drop_next     = drop_reg;
    if_valid_next = if_valid_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_next = WAIT;
          drop_next  = redirect;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_reg || redirect) begin
            state_next = REQ;
            drop_next  = 1'b0;
          end else begin
            state_next    = HOLD;
            if_valid_next = 1'b1;
          end
        end else if (redirect) begin
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || if_ready) begin
          state_next    = REQ;
          if_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      drop_reg     <= 1'b0;
      pc_reg       <= RESET_PC;
      if_valid_reg <= 1'b0;
      if_pc_reg    <= 32'h0;
      if_instr_reg <= 32'h0;
    end else begin
      state_reg    <= state_next;
      drop_reg     <= drop_next;
      if_valid_reg <= if_valid_next;
      if (pc_load) pc_reg <= pc_load_val;
      if (capture) begin
        if_pc_reg    <= pc_reg;
        if_instr_reg <= imem_rsp_data;
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_reg;
  logic [31:0] epc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_reg <= 1'b0;
      epc_reg  <= 32'h0;
    end else begin
      trap_reg <= pc_load && misaligned;
      if (pc_load && misaligned) epc_reg <= next_pc;
    end
  end

  assign misalign_trap = trap_reg;
  assign misalign_epc  = epc_reg;
`endif

  assign pc             = pc_reg;
  assign pc_plus4       = pc_reg + 32'd4;
  assign imem_req_valid = (state_reg == REQ);
  assign imem_addr      = pc_reg;
  assign if_valid       = if_valid_reg;
  assign if_pc          = if_pc_reg;
  assign if_instr       = if_instr_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: fetch sequencing, stalls, redirects, misaligned loads, reset abort.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] pc, pc_plus4;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] misalign_epc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .redirect(redirect),
    .pc(pc), .pc_plus4(pc_plus4),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap), .misalign_epc(misalign_epc),
`endif
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept the request at the current pc, respond next cycle, land in HOLD.
  task automatic fetch_to_hold(input logic [31:0] addr, input logic [31:0] data);
    check("req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req_addr", imem_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("wait_req_low", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    check("if_valid", {31'b0, if_valid}, 32'd1);
    check("if_pc", if_pc, addr);
    check("if_instr", if_instr, data);
  endtask

  task automatic handshake(input logic [31:0] npc);
    if_ready = 1'b1;
    next_pc  = npc;
    tick();
    if_ready = 1'b0;
    check("hs_if_valid", {31'b0, if_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; next_pc = 32'h0; redirect = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst_n = 1'b1;
    check("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();

    // Sequential fetches 0, 4, 8
    fetch_to_hold(32'h0, 32'h0011_2233);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_if_valid", {31'b0, if_valid}, 32'd1);
      check("stall_if_pc", if_pc, 32'h0);
      check("stall_if_instr", if_instr, 32'h0011_2233);
      check("stall_pc", pc, 32'h0);
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    end
    check("pc_plus4_0", pc_plus4, 32'h4);
    handshake(32'h4);
    check("pc_after_hs", pc, 32'h4);
    check("pc_plus4_4", pc_plus4, 32'h8);
    fetch_to_hold(32'h4, 32'hA000_0004);
    handshake(32'h8);

    // Request not accepted for 4 cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nrdy_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("nrdy_addr", imem_addr, 32'h8);
    end
    fetch_to_hold(32'h8, 32'hA000_0008);
    handshake(32'h10);

    // Redirect together with if_ready in HOLD squashes the packet
    fetch_to_hold(32'h10, 32'hA000_0010);
    redirect = 1'b1; if_ready = 1'b1; next_pc = 32'h200;
    tick();
    redirect = 1'b0; if_ready = 1'b0;
    check("sq_if_valid", {31'b0, if_valid}, 32'd0);
    check("sq_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("sq_addr", imem_addr, 32'h200);

    // Redirect in WAIT; the response two cycles later is dropped
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect = 1'b1; next_pc = 32'h400;
    tick();
    redirect = 1'b0;
    check("rw_pc", pc, 32'h400);
    check("rw_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("drop_if_valid", {31'b0, if_valid}, 32'd0);
    fetch_to_hold(32'h400, 32'h0000_0055);

    // Misaligned next_pc on the HOLD handshake
    handshake(32'h102);
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_pc", pc, 32'h80);
    check("mis_trap", {31'b0, misalign_trap}, 32'd1);
    check("mis_epc", misalign_epc, 32'h102);
    tick();
    check("mis_trap_pulse", {31'b0, misalign_trap}, 32'd0);
    check("mis_epc_hold", misalign_epc, 32'h102);
`else
    check("mis_pc", pc, 32'h100);
    tick();
    check("mis_pc_hold", pc, 32'h100);
`endif

    // Asynchronous reset mid-request, then a stray response in IDLE
    check("pre_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    check("arst_epc", misalign_epc, 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    check("late_rsp_if_valid", {31'b0, if_valid}, 32'd0);
    check("late_rsp_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("late_rsp_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
